// File: rtl/srt_div_pkg.sv
// Shared widths and the IEEE-754 single-precision word layout for the SRT divider.
package srt_div_pkg;

    localparam int unsigned MANT_W  = 24;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned FRAC_W  = MANT_W - 1;
    localparam int unsigned E_W     = 10;
    localparam int unsigned WORD_W  = 1 + EXP_W + FRAC_W;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/post_processing_if.sv
// Input/output bundle of the divider post-processing stage.
// PP_EXC_FLAGS_EN adds the overflow/underflow flag signals.
interface post_processing_if;
    import srt_div_pkg::*;

    logic               in_valid;
    logic [MANT_W-1:0]  result;
    logic [SHAMT_W-1:0] shift_nums;
    logic               right_shift;
    logic               resultsign;
    logic [EXP_W-1:0]   current_exponent;
    logic [WORD_W-1:0]  quotient;
    logic               out_valid;
`ifdef PP_EXC_FLAGS_EN
    logic               overflow;
    logic               underflow;
`endif

    modport master (
        output in_valid, result, shift_nums, right_shift, resultsign, current_exponent,
`ifdef PP_EXC_FLAGS_EN
        input  overflow, underflow,
`endif
        input  quotient, out_valid
    );

    modport slave (
        input  in_valid, result, shift_nums, right_shift, resultsign, current_exponent,
`ifdef PP_EXC_FLAGS_EN
        output overflow, underflow,
`endif
        output quotient, out_valid
    );

endinterface

// File: rtl/pp_norm_shift.sv
// Combinational bidirectional mantissa shifter plus the matching exponent adjust.
module pp_norm_shift
    import srt_div_pkg::*;
(
    input  logic                   [MANT_W-1:0]  result_i,
    input  logic                   [SHAMT_W-1:0] shift_nums_i,
    input  logic                                 right_shift_i,
    input  logic                   [EXP_W-1:0]   exponent_i,
    output logic                   [MANT_W-1:0]  m_c_o,
    output logic signed            [E_W-1:0]     e_c_o
);

    logic signed [E_W-1:0] exp_s;
    logic signed [E_W-1:0] shamt_s;

    // Zero-extend both operands so the 10-bit signed sum can go negative or above 255.
    assign exp_s   = $signed({{(E_W-EXP_W){1'b0}}, exponent_i});
    assign shamt_s = $signed({{(E_W-SHAMT_W){1'b0}}, shift_nums_i});

    always_comb begin
        m_c_o = result_i << shift_nums_i;
        e_c_o = exp_s - shamt_s;
        if (right_shift_i) begin
            m_c_o = result_i >> shift_nums_i;
            e_c_o = exp_s + shamt_s;
        end
    end

endmodule

// File: rtl/post_processing.sv
// SRT divider final stage: normalise, saturate/flush, pack an IEEE-754 single word.
// PP_EXC_FLAGS_EN adds registered overflow/underflow flags.
module post_processing
    import srt_div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    post_processing_if.slave  pp
);

    localparam logic signed [E_W-1:0] E_OVF  = 10'sd255;
    localparam logic signed [E_W-1:0] E_ZERO = 10'sd0;

    logic [MANT_W-1:0]     m_c;
    logic signed [E_W-1:0] e_c;
    logic                  m_msb_unused;

    fp32_t quotient_d, quotient_q;
    logic  out_valid_q;
    logic  ovf_d, ovf_q;
    logic  unf_d, unf_q;

    pp_norm_shift u_norm (
        .result_i      (pp.result),
        .shift_nums_i  (pp.shift_nums),
        .right_shift_i (pp.right_shift),
        .exponent_i    (pp.current_exponent),
        .m_c_o         (m_c),
        .e_c_o         (e_c)
    );

    // The implicit leading one is not stored and is not checked here.
    assign m_msb_unused = m_c[MANT_W-1];

    // Special-case priority: zero result, then overflow, then underflow.
    always_comb begin
        quotient_d = quotient_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        if (pp.in_valid) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            quotient_d.sign = pp.resultsign;
            quotient_d.exp  = e_c[EXP_W-1:0];
            quotient_d.frac = m_c[FRAC_W-1:0];
            if (pp.result == '0) begin
                quotient_d.exp  = '0;
                quotient_d.frac = '0;
            end else if (e_c >= E_OVF) begin
                quotient_d.exp  = EXP_MAX;
                quotient_d.frac = '0;
                ovf_d           = 1'b1;
            end else if (e_c <= E_ZERO) begin
                quotient_d.exp  = '0;
                quotient_d.frac = '0;
                unf_d           = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            quotient_q  <= quotient_d;
            out_valid_q <= pp.in_valid;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign pp.quotient  = quotient_q;
    assign pp.out_valid = out_valid_q;
`ifdef PP_EXC_FLAGS_EN
    assign pp.overflow  = ovf_q;
    assign pp.underflow = unf_q;
`endif

endmodule

// File: tb/tb_post_processing.sv
// Directed scoreboard bench for the divider post-processing stage.
module tb_post_processing;
    import srt_div_pkg::*;

    typedef struct {
        logic [31:0] q;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [31:0] exp_hold = 32'h0;
    exp_t sb[$];

    post_processing_if pp ();

    post_processing dut (
        .clk (clk),
        .rst (rst),
        .pp  (pp)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [23:0] res, input logic [4:0] sh, input logic rs,
                         input logic sign, input logic [7:0] ex,
                         input logic [31:0] q, input logic ovf, input logic unf);
        exp_t e;
        @(posedge clk);
        #2;
        pp.in_valid         = 1'b1;
        pp.result           = res;
        pp.shift_nums       = sh;
        pp.right_shift      = rs;
        pp.resultsign       = sign;
        pp.current_exponent = ex;
        e.q = q; e.ovf = ovf; e.unf = unf;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        pp.in_valid = 1'b0;
        pp.result   = 24'hABCDEF;
    endtask

    // Monitor: pop an expectation for every valid output, otherwise the word must hold.
    always @(negedge clk) begin
        exp_t e;
        if (pp.out_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got quotient %h, expected no output", pp.quotient);
            end else begin
                e = sb.pop_front();
                check32("quotient", pp.quotient, e.q);
`ifdef PP_EXC_FLAGS_EN
                check32("overflow", 32'(pp.overflow), 32'(e.ovf));
                check32("underflow", 32'(pp.underflow), 32'(e.unf));
`endif
                exp_hold = e.q;
            end
        end else begin
            check32("hold", pp.quotient, exp_hold);
        end
    end

    initial begin
        pp.in_valid         = 1'b0;
        pp.result           = '0;
        pp.shift_nums       = '0;
        pp.right_shift      = 1'b0;
        pp.resultsign       = 1'b0;
        pp.current_exponent = '0;
        #1;
        check32("reset_quotient", pp.quotient, 32'h0);
        check32("reset_out_valid", 32'(pp.out_valid), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        issue(24'h400000, 5'd1, 1'b0, 1'b0, 8'd127, 32'h3F000000, 1'b0, 1'b0);
        issue(24'h800000, 5'd0, 1'b0, 1'b1, 8'd128, 32'hC0000000, 1'b0, 1'b0);
        issue(24'h800001, 5'd1, 1'b1, 1'b0, 8'd127, 32'h40400000, 1'b0, 1'b0);
        issue(24'h800000, 5'd3, 1'b1, 1'b0, 8'd254, 32'h7F800000, 1'b1, 1'b0);
        issue(24'h400000, 5'd5, 1'b0, 1'b1, 8'd2,   32'h80000000, 1'b0, 1'b1);
        idle();
        idle();
        issue(24'h000000, 5'd0, 1'b0, 1'b1, 8'd100, 32'h80000000, 1'b0, 1'b0);
        issue(24'h000000, 5'd31, 1'b1, 1'b0, 8'd250, 32'h00000000, 1'b0, 1'b0);
        issue(24'h800000, 5'd1, 1'b1, 1'b0, 8'd254, 32'h7F800000, 1'b1, 1'b0);
        issue(24'h800000, 5'd0, 1'b1, 1'b1, 8'd254, 32'hFF000000, 1'b0, 1'b0);
        issue(24'h800000, 5'd0, 1'b0, 1'b0, 8'd0,   32'h00000000, 1'b0, 1'b1);
        issue(24'h400000, 5'd1, 1'b0, 1'b0, 8'd2,   32'h00800000, 1'b0, 1'b0);
        idle();
        issue(24'h000001, 5'd23, 1'b0, 1'b0, 8'd150, 32'h3F800000, 1'b0, 1'b0);
        issue(24'hC00000, 5'd0, 1'b1, 1'b0, 8'd127, 32'h3FC00000, 1'b0, 1'b0);
        issue(24'h012345, 5'd7, 1'b0, 1'b0, 8'd130, 32'h3D91A280, 1'b0, 1'b0);
        idle();

        // Mid-stream reset: the first item has been checked, the second is in flight.
        issue(24'h800000, 5'd0, 1'b0, 1'b0, 8'd129, 32'h40800000, 1'b0, 1'b0);
        issue(24'hC00000, 5'd0, 1'b0, 1'b1, 8'd129, 32'hC0C00000, 1'b0, 1'b0);
        #5;
        rst = 1'b1;
        #1;
        check32("async_reset_quotient", pp.quotient, 32'h0);
        check32("async_reset_out_valid", 32'(pp.out_valid), 32'h0);
        sb.delete();
        exp_hold = 32'h0;
        @(posedge clk);
        #2;
        pp.in_valid = 1'b0;
        rst = 1'b0;
        issue(24'h800000, 5'd0, 1'b0, 1'b1, 8'd127, 32'hBF800000, 1'b0, 1'b0);
        idle();
        repeat (3) @(posedge clk);
        #2;
        check32("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
